// File: rtl/clock_pkg.sv
// Shared definitions for the hours/minutes/seconds clock: FSM state encoding,
// field limits and a binary-to-BCD helper used for constant reset values.
package clock_pkg;

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_SET_HOUR = 2'b01;
    localparam logic [1:0] ST_SET_MIN  = 2'b10;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    // Two-digit BCD of a small binary value (0-99); tens in [7:4], ones in [3:0].
    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'((v / 10) % 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX. load has priority over inc;
// carry is a combinational flag marking the increment that wraps the field,
// so an upstream carry can be chained within the same cycle.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [7:0] value,
    output logic       carry
);

    localparam logic [7:0] MAX_BCD = to_bcd(MAX);

    logic at_max;

    assign at_max = (value == MAX_BCD);
    assign carry  = inc && at_max && !load;

    // Load, else wrap at MAX, else BCD increment with ones-to-tens carry.
    always_ff @(posedge clk) begin
        if (load) begin
            value <= load_value;
        end else if (inc) begin
            if (at_max) begin
                value <= 8'h00;
            end else if (value[3:0] == 4'd9) begin
                value <= {value[7:4] + 4'd1, 4'd0};
            end else begin
                value <= {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/hms_time_counter.sv
// Time-of-day counter (HH:MM:SS, BCD) with a three-state set FSM:
// RUN counts seconds on tick; SET_HOUR / SET_MIN let inc_btn step one field
// without carrying. Leaving SET_MIN clears seconds. Reset is synchronous and
// reloads the counters through their load path.
module hms_time_counter
    import clock_pkg::*;
#(
    parameter int RESET_HOUR = 0,
    parameter int RESET_MIN  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] set_state,
    output logic       day_wrap
);

    localparam logic [7:0] RESET_HOUR_BCD = to_bcd(RESET_HOUR);
    localparam logic [7:0] RESET_MIN_BCD  = to_bcd(RESET_MIN);

    logic [1:0] state;
    logic       in_run;
    logic       in_set_hour;
    logic       in_set_min;
    logic       inc_eff;
    logic       sec_inc;
    logic       sec_load;
    logic       sec_carry;
    logic       min_inc;
    logic       min_carry;
    logic       hour_inc;
    logic       hour_carry;

    assign in_run      = (state == ST_RUN);
    assign in_set_hour = (state == ST_SET_HOUR);
    assign in_set_min  = (state == ST_SET_MIN);

    // mode_btn wins over a simultaneous inc_btn.
    assign inc_eff  = inc_btn && !mode_btn;

    assign sec_inc  = in_run && tick;
    assign sec_load = reset || (in_set_min && mode_btn);

    // Run-mode carries chain combinationally so all fields update on one edge;
    // set-mode increments never feed a carry onward.
    assign min_inc  = (sec_inc && sec_carry) || (in_set_min && inc_eff);
    assign hour_inc = (sec_inc && sec_carry && min_carry) || (in_set_hour && inc_eff);

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk        (clk),
        .inc        (sec_inc),
        .load       (sec_load),
        .load_value (8'h00),
        .value      (sec_bcd),
        .carry      (sec_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk        (clk),
        .inc        (min_inc),
        .load       (reset),
        .load_value (RESET_MIN_BCD),
        .value      (min_bcd),
        .carry      (min_carry)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk        (clk),
        .inc        (hour_inc),
        .load       (reset),
        .load_value (RESET_HOUR_BCD),
        .value      (hour_bcd),
        .carry      (hour_carry)
    );

    // Mode FSM: RUN -> SET_HOUR -> SET_MIN -> RUN on each mode_btn pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else if (mode_btn) begin
            case (state)
                ST_RUN:      state <= ST_SET_HOUR;
                ST_SET_HOUR: state <= ST_SET_MIN;
                default:     state <= ST_RUN;
            endcase
        end
    end

    assign set_state = state;

    // One-cycle flag aligned with the 00:00:00 that follows 23:59:59.
    always_ff @(posedge clk) begin
        if (reset) begin
            day_wrap <= 1'b0;
        end else begin
            day_wrap <= sec_inc && hour_carry;
        end
    end

endmodule

// File: tb/tb_hms_time_counter.sv
// Scoreboard bench: the driver pushes expected outputs per cycle, a monitor
// on the falling edge pops and compares. Instance A uses default parameters,
// instance B uses RESET_HOUR = 12; both share the same stimulus.
module tb_hms_time_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [7:0] a_hour, a_min, a_sec, b_hour, b_min, b_sec;
    logic [1:0] a_st, b_st;
    logic       a_dw, b_dw;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        bit         full;
        bit         which;
        string      name;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic [1:0] st;
        logic       dw;
    } exp_t;

    exp_t q[$];

    hms_time_counter u_a (
        .clk(clk), .reset(reset), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .hour_bcd(a_hour), .min_bcd(a_min), .sec_bcd(a_sec), .set_state(a_st), .day_wrap(a_dw)
    );

    hms_time_counter #(.RESET_HOUR(12), .RESET_MIN(0)) u_b (
        .clk(clk), .reset(reset), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .hour_bcd(b_hour), .min_bcd(b_min), .sec_bcd(b_sec), .set_state(b_st), .day_wrap(b_dw)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this falling edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [32:0] act, req;
            e = q.pop_front();
            n_cmp++;
            if (e.cyc < cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else begin
                if (e.which)
                    act = {b_hour, b_min, b_sec, 6'd0, b_st, 1'b0, b_dw};
                else
                    act = {a_hour, a_min, a_sec, 6'd0, a_st, 1'b0, a_dw};
                req = {e.h, e.m, e.s, 6'd0, e.st, 1'b0, e.dw};
                if (!e.full) begin
                    act = {32'd0, act[0]};
                    req = {32'd0, req[0]};
                end
                if (act !== req) begin
                    n_bad++;
                    $display("FAIL %s: got %h:%h:%h st=%b dw=%b, expected %h:%h:%h st=%b dw=%b (full=%0d)",
                             e.name, act[32:25], act[24:17], act[16:9], act[2:1], act[0],
                             e.h, e.m, e.s, e.st, e.dw, e.full);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic t, input logic m, input logic i);
        @(negedge clk);
        #1;
        reset    = r;
        tick     = t;
        mode_btn = m;
        inc_btn  = i;
    endtask

    // n cycles of the same inputs; only day_wrap (must stay 0) is checked.
    task automatic go(input logic r, input logic t, input logic m, input logic i, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            drive(r, t, m, i);
            e.cyc = cyc + 1; e.full = 1'b0; e.which = 1'b0; e.name = "no_day_wrap";
            e.h = 8'h00; e.m = 8'h00; e.s = 8'h00; e.st = 2'b00; e.dw = 1'b0;
            q.push_back(e);
        end
    endtask

    // One cycle of inputs with a full expected output image after the edge.
    task automatic go_chk(input logic r, input logic t, input logic m, input logic i,
                          input string name, input logic [7:0] h, input logic [7:0] mi,
                          input logic [7:0] s, input logic [1:0] st, input logic dw,
                          input bit which);
        exp_t e;
        drive(r, t, m, i);
        e.cyc = cyc + 1; e.full = 1'b1; e.which = which; e.name = name;
        e.h = h; e.m = mi; e.s = s; e.st = st; e.dw = dw;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state for both parameterisations.
        go_chk(1, 0, 0, 0, "reset_a", 8'h00, 8'h00, 8'h00, 2'b00, 0, 0);
        go_chk(1, 0, 0, 0, "reset_b", 8'h12, 8'h00, 8'h00, 2'b00, 0, 1);

        // 61 ticks from reset.
        go(0, 1, 0, 0, 59);
        go_chk(0, 1, 0, 0, "sec_wrap", 8'h00, 8'h01, 8'h00, 2'b00, 0, 0);
        go_chk(0, 1, 0, 0, "run_61", 8'h00, 8'h01, 8'h01, 2'b00, 0, 0);

        // Hour and minute setting with wraps and no carry.
        go_chk(1, 0, 0, 0, "reset2", 8'h00, 8'h00, 8'h00, 2'b00, 0, 0);
        go_chk(0, 0, 1, 0, "to_set_hour", 8'h00, 8'h00, 8'h00, 2'b01, 0, 0);
        go(0, 0, 0, 1, 23);
        go_chk(0, 0, 0, 1, "hour_wrap", 8'h00, 8'h00, 8'h00, 2'b01, 0, 0);
        go_chk(0, 0, 0, 1, "hour_25", 8'h01, 8'h00, 8'h00, 2'b01, 0, 0);
        go_chk(0, 0, 1, 0, "to_set_min", 8'h01, 8'h00, 8'h00, 2'b10, 0, 0);
        go(0, 0, 0, 1, 59);
        go_chk(0, 0, 0, 1, "min_wrap", 8'h01, 8'h00, 8'h00, 2'b10, 0, 0);
        go_chk(0, 0, 0, 1, "min_61", 8'h01, 8'h01, 8'h00, 2'b10, 0, 0);

        // inc ignored in RUN; mode+inc together in SET_HOUR.
        go_chk(0, 0, 1, 0, "to_run", 8'h01, 8'h01, 8'h00, 2'b00, 0, 0);
        go_chk(0, 0, 0, 1, "inc_in_run", 8'h01, 8'h01, 8'h00, 2'b00, 0, 0);
        go_chk(0, 0, 1, 0, "to_set_hour2", 8'h01, 8'h01, 8'h00, 2'b01, 0, 0);
        go_chk(0, 0, 1, 1, "mode_and_inc", 8'h01, 8'h01, 8'h00, 2'b10, 0, 0);
        go_chk(0, 0, 1, 0, "back_run", 8'h01, 8'h01, 8'h00, 2'b00, 0, 0);

        // Minute-to-hour carry without day wrap: 00:59:59 -> 01:00:00.
        go(1, 0, 0, 0, 1);
        go(0, 0, 1, 0, 2);
        go(0, 0, 0, 1, 59);
        go_chk(0, 0, 1, 0, "exit_set_min", 8'h00, 8'h59, 8'h00, 2'b00, 0, 0);
        go(0, 1, 0, 0, 59);
        go_chk(0, 1, 0, 0, "min_carry", 8'h01, 8'h00, 8'h00, 2'b00, 0, 0);

        // Preload 23:59 via set states, run to 23:59:58, then day wrap.
        go(1, 0, 0, 0, 1);
        go(0, 0, 1, 0, 1);
        go(0, 0, 0, 1, 23);
        go(0, 0, 1, 0, 1);
        go(0, 0, 0, 1, 59);
        go_chk(0, 0, 1, 0, "preload", 8'h23, 8'h59, 8'h00, 2'b00, 0, 0);
        go(0, 1, 0, 0, 57);
        go_chk(0, 1, 0, 0, "at_58", 8'h23, 8'h59, 8'h58, 2'b00, 0, 0);
        go_chk(0, 1, 0, 0, "at_59", 8'h23, 8'h59, 8'h59, 2'b00, 0, 0);
        go_chk(0, 1, 0, 0, "day_wrap", 8'h00, 8'h00, 8'h00, 2'b00, 1, 0);
        go_chk(0, 0, 0, 0, "wrap_once", 8'h00, 8'h00, 8'h00, 2'b00, 0, 0);

        // Seconds at 37: tick+mode in RUN, ticks ignored in set states.
        go(0, 1, 0, 0, 36);
        go_chk(0, 1, 1, 0, "tick_and_mode", 8'h00, 8'h00, 8'h37, 2'b01, 0, 0);
        go_chk(0, 1, 0, 0, "tick_set_hour", 8'h00, 8'h00, 8'h37, 2'b01, 0, 0);
        go_chk(0, 0, 1, 0, "to_set_min3", 8'h00, 8'h00, 8'h37, 2'b10, 0, 0);
        go(0, 1, 0, 0, 4);
        go_chk(0, 1, 0, 0, "sec_hold", 8'h00, 8'h00, 8'h37, 2'b10, 0, 0);
        go_chk(0, 0, 1, 0, "sec_clear", 8'h00, 8'h00, 8'h00, 2'b00, 0, 0);

        // Reset in the middle of SET_MIN (instance B resets to 12:00).
        go(1, 0, 0, 0, 1);
        go(0, 0, 1, 0, 2);
        go_chk(0, 0, 0, 1, "b_set_min", 8'h12, 8'h01, 8'h00, 2'b10, 0, 1);
        go(0, 0, 0, 1, 2);
        go_chk(1, 1, 1, 1, "b_reset_mid_set", 8'h12, 8'h00, 8'h00, 2'b00, 0, 1);
        go_chk(0, 0, 0, 0, "a_after_reset", 8'h00, 8'h00, 8'h00, 2'b00, 0, 0);

        drive(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #2;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hms_time_counter.md
HMS_TIME_COUNTER -- requirements
Module: hms_time_counter

Interface
REQ-001 The block SHALL have parameter RESET_HOUR, default 0, meaning the hour (0-23, binary) loaded on reset.
REQ-002 The block SHALL have parameter RESET_MIN, default 0, meaning the minute (0-59, binary) loaded on reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port tick, input, 1 bit: one-cycle one-second pulse from the upstream clock divider.
REQ-006 The block SHALL have port mode_btn, input, 1 bit: one-cycle debounced pulse that advances the mode.
REQ-007 The block SHALL have port inc_btn, input, 1 bit: one-cycle debounced pulse that increments the field being set.
REQ-008 The block SHALL have ports hour_bcd, min_bcd and sec_bcd, each output, 8 bits: two BCD digits, tens digit in [7:4] and ones digit in [3:0].
REQ-009 The block SHALL have port set_state, output, 2 bits: 00 = RUN, 01 = SET_HOUR, 10 = SET_MIN.
REQ-010 The block SHALL have port day_wrap, output, 1 bit: one-cycle pulse when 23:59:59 advances to 00:00:00.

Function
REQ-011 All outputs SHALL be registered; a time output SHALL change on the clk edge that samples the triggering tick or inc_btn, with latency 1 cycle.
REQ-012 The FSM SHALL have states RUN, SET_HOUR and SET_MIN; mode_btn SHALL move RUN->SET_HOUR->SET_MIN->RUN, and the FSM SHALL otherwise hold its state.
REQ-013 In RUN, tick SHALL advance seconds 00..59; at 59 seconds SHALL wrap to 00 and carry to minutes.
REQ-014 Minutes SHALL count 00..59 with the same wrap-and-carry into hours.
REQ-015 Hours SHALL count 00..23 and wrap to 00.
REQ-016 A carry SHALL be applied in the same cycle as the tick that generates it; no ripple delay SHALL be visible on the outputs.
REQ-017 day_wrap SHALL be 1 for exactly the cycle in which the outputs show 00:00:00 after a wrap from 23:59:59, and 0 at all other times.
REQ-018 In SET_HOUR, inc_btn SHALL increment hours modulo 24 without carrying into any other field.
REQ-019 In SET_MIN, inc_btn SHALL increment minutes modulo 60 without carrying into hours.
REQ-020 In SET_HOUR and SET_MIN, tick SHALL be ignored and seconds SHALL hold their value.
REQ-021 The SET_MIN->RUN transition SHALL clear seconds to 00 in the same cycle.
REQ-022 In RUN, inc_btn SHALL be ignored.
REQ-023 If mode_btn and inc_btn are asserted in the same cycle, mode_btn SHALL take effect and inc_btn SHALL be dropped.
REQ-024 If tick and mode_btn are asserted in the same cycle in RUN, the tick SHALL be applied and the FSM SHALL move to SET_HOUR.
REQ-025 Every digit SHALL always hold a legal BCD value (0-9), and every field SHALL stay within its modulus.

Reset
REQ-026 When reset is asserted, the block SHALL set hours to RESET_HOUR and minutes to RESET_MIN (both converted to BCD), seconds to 00, state to RUN and day_wrap to 0.
REQ-027 reset SHALL take priority over tick, mode_btn and inc_btn in the same cycle, including in the middle of a set operation.

Structure
REQ-028 A shared package clock_pkg SHALL hold the FSM state encoding and the constants SEC_MAX = 59, MIN_MAX = 59 and HOUR_MAX = 23.
REQ-029 A sub-module bcd_mod_counter SHALL implement one two-digit BCD counter: parameterised max value, inputs inc, load and load_value, outputs value and carry; it SHALL be instantiated three times.

Verification
REQ-030 Reset with default parameters, then 61 ticks -> outputs read 00:01:01 and set_state = 00.
REQ-031 Preload 23:59:58 via the SET states, then 2 ticks -> 23:59:59, then 00:00:00 with day_wrap high for exactly one cycle.
REQ-032 Reset, then 1 mode_btn and 25 inc_btn -> hour_bcd = 0x01; then 1 mode_btn and 61 inc_btn -> min_bcd = 0x01 with hour_bcd still 0x01.
REQ-033 In SET_MIN with seconds at 0x37, 5 ticks -> seconds hold 0x37; then 1 mode_btn -> set_state = 00 and sec_bcd = 0x00.
REQ-034 In SET_HOUR, assert mode_btn and inc_btn together -> state becomes SET_MIN and hours are unchanged.
REQ-035 Assert reset in the middle of SET_MIN with RESET_HOUR = 12 -> next cycle outputs read 12:00:00 and set_state = 00.
